// File: rtl/pe_line_pkg.sv
// rtl/pe_line_pkg.sv - shared FSM state type and arithmetic helpers for the PE line
// PE_LINE_SAD_SAT_EN selects a saturating accumulator add instead of modulo wrap.
package pe_line_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Operands and result are held in 32 bits; w is the real accumulator width.
  function automatic logic [31:0] acc_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] lim;
    lim = (33'd1 << w) - 33'd1;
    sum = {1'b0, a} + {1'b0, b};
`ifdef PE_LINE_SAD_SAT_EN
    if (sum > lim) sum = lim;
`else
    sum = sum & lim;
`endif
    return 32'(sum);
  endfunction

endpackage

// File: rtl/pe_sad_cell.sv
// rtl/pe_sad_cell.sv - one processing element: SW/TB pixel registers, |sw-tb| and SAD accumulator
// Add behaviour follows PE_LINE_SAD_SAT_EN through pe_line_pkg::acc_add.
module pe_sad_cell
  import pe_line_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_sw,
  input  logic             en_tb,
  input  logic [PIX_W-1:0] sw_in,
  input  logic [PIX_W-1:0] tb_in,
  input  logic             acc_load,
  input  logic             add_en,
  input  logic             sad_load,
  output logic [PIX_W-1:0] sw_out,
  output logic [PIX_W-1:0] tb_out,
  output logic [PIX_W-1:0] ad,
  output logic [ACC_W-1:0] sad
);

  logic [PIX_W-1:0] sw_q, sw_d;
  logic [PIX_W-1:0] tb_q, tb_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] sad_q, sad_d;

  always_comb begin
    sw_d  = en_sw ? sw_in : sw_q;
    tb_d  = en_tb ? tb_in : tb_q;
    ad    = PIX_W'(abs_diff(32'(sw_q), 32'(tb_q)));
    acc_d = acc_q;
    if (acc_load) begin
      acc_d = ACC_W'(ad);
    end else if (add_en) begin
      acc_d = ACC_W'(acc_add(32'(acc_q), 32'(ad), ACC_W));
    end
    // The last beat's sum is captured directly so sad is ready alongside sad_valid.
    sad_d = sad_load ? acc_d : sad_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_q  <= '0;
      tb_q  <= '0;
      acc_q <= '0;
      sad_q <= '0;
    end else begin
      sw_q  <= sw_d;
      tb_q  <= tb_d;
      acc_q <= acc_d;
      sad_q <= sad_d;
    end
  end

  assign sw_out = sw_q;
  assign tb_out = tb_q;
  assign sad    = sad_q;

endmodule

// File: rtl/pe_line_sad.sv
// rtl/pe_line_sad.sv - systolic PE line with shared block-SAD FSM and SW/TB cascade outputs
// PE_LINE_SAD_SAT_EN (in pe_line_pkg) switches accumulators from wrap to saturate.
module pe_line_sad
  import pe_line_pkg::*;
#(
  parameter int ARRAY_SIZE = 16,
  parameter int PIX_W      = 8,
  parameter int ACC_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en_sw,
  input  logic                        en_tb,
  input  logic [PIX_W-1:0]            pel_sw,
  input  logic [PIX_W-1:0]            pel_tb,
  output logic [PIX_W-1:0]            nxt_sw,
  output logic [PIX_W-1:0]            nxt_tb,
  input  logic                        acc_en,
  input  logic                        acc_start,
  input  logic                        acc_last,
  output logic [ARRAY_SIZE*PIX_W-1:0] ad,
  output logic [ARRAY_SIZE*ACC_W-1:0] sad,
  output logic                        sad_valid,
  output logic                        busy
);

  state_e state_q, state_d;
  logic   acc_load, add_en, sad_load;

  always_comb begin
    state_d  = state_q;
    acc_load = 1'b0;
    add_en   = 1'b0;
    sad_load = 1'b0;
    // A start restarts the block from any state; plain beats only count inside ACC.
    if (acc_en && acc_start) begin
      acc_load = 1'b1;
      sad_load = acc_last;
      state_d  = acc_last ? ST_DONE : ST_ACC;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (acc_en) begin
            add_en   = 1'b1;
            sad_load = acc_last;
            state_d  = acc_last ? ST_DONE : ST_ACC;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  assign sad_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);

  logic [PIX_W-1:0] sw_link [ARRAY_SIZE+1];
  logic [PIX_W-1:0] tb_link [ARRAY_SIZE+1];

  assign sw_link[0] = pel_sw;
  assign tb_link[0] = pel_tb;

  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_pe
    pe_sad_cell #(
      .PIX_W(PIX_W),
      .ACC_W(ACC_W)
    ) u_cell (
      .clk     (clk),
      .rst     (rst),
      .en_sw   (en_sw),
      .en_tb   (en_tb),
      .sw_in   (sw_link[i]),
      .tb_in   (tb_link[i]),
      .acc_load(acc_load),
      .add_en  (add_en),
      .sad_load(sad_load),
      .sw_out  (sw_link[i+1]),
      .tb_out  (tb_link[i+1]),
      .ad      (ad[PIX_W*i +: PIX_W]),
      .sad     (sad[ACC_W*i +: ACC_W])
    );
  end

  assign nxt_sw = sw_link[ARRAY_SIZE];
  assign nxt_tb = tb_link[ARRAY_SIZE];

endmodule

// File: tb/tb_pe_line_sad.sv
// tb/tb_pe_line_sad.sv - directed bench for pe_line_sad (4 PEs; 12-bit and 10-bit accumulators)
// Expected overflow result follows PE_LINE_SAD_SAT_EN.
module tb_pe_line_sad;

  localparam int N  = 4;
  localparam int PW = 8;
  localparam int AW = 12;
  localparam int OW = 10;

  logic            clk = 1'b0;
  logic            rst;
  logic            en_sw, en_tb;
  logic [PW-1:0]   pel_sw, pel_tb;
  logic            acc_en, acc_start, acc_last;
  logic [PW-1:0]   nxt_sw, nxt_tb, nxt_sw_o, nxt_tb_o;
  logic [N*PW-1:0] ad, ad_o;
  logic [N*AW-1:0] sad;
  logic [N*OW-1:0] sad_o;
  logic            sad_valid, busy, sad_valid_o, busy_o;

  int vec_cnt  = 0;
  int fail_cnt = 0;

  always #5 clk = ~clk;

  pe_line_sad #(.ARRAY_SIZE(N), .PIX_W(PW), .ACC_W(AW)) u_dut (
    .clk(clk), .rst(rst), .en_sw(en_sw), .en_tb(en_tb),
    .pel_sw(pel_sw), .pel_tb(pel_tb), .nxt_sw(nxt_sw), .nxt_tb(nxt_tb),
    .acc_en(acc_en), .acc_start(acc_start), .acc_last(acc_last),
    .ad(ad), .sad(sad), .sad_valid(sad_valid), .busy(busy)
  );

  pe_line_sad #(.ARRAY_SIZE(N), .PIX_W(PW), .ACC_W(OW)) u_dut_ovf (
    .clk(clk), .rst(rst), .en_sw(en_sw), .en_tb(en_tb),
    .pel_sw(pel_sw), .pel_tb(pel_tb), .nxt_sw(nxt_sw_o), .nxt_tb(nxt_tb_o),
    .acc_en(acc_en), .acc_start(acc_start), .acc_last(acc_last),
    .ad(ad_o), .sad(sad_o), .sad_valid(sad_valid_o), .busy(busy_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    en_sw = 0; en_tb = 0; pel_sw = '0; pel_tb = '0;
    acc_en = 0; acc_start = 0; acc_last = 0;
  endtask

  task automatic beat(input logic s, input logic l);
    acc_en = 1; acc_start = s; acc_last = l;
    tick();
    acc_en = 0; acc_start = 0; acc_last = 0;
  endtask

  initial begin
    idle_in();
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      en_sw = 1'($urandom); en_tb = 1'($urandom);
      pel_sw = PW'($urandom); pel_tb = PW'($urandom);
      acc_en = 1'($urandom); acc_start = 1'($urandom); acc_last = 1'($urandom);
      tick();
    end
    rst = 0;
    idle_in();
    chk("rst_ad", 64'(ad), 64'd0);
    chk("rst_sad", 64'(sad), 64'd0);
    chk("rst_nxt", {nxt_sw, nxt_tb}, 64'd0);
    chk("rst_flags", {sad_valid, busy}, 64'd0);

    // Chain: sw 10,20,30,40 with tb 5 -> PE0 holds 40, PE3 holds 10
    for (int i = 1; i <= 4; i++) begin
      en_sw = 1; en_tb = 1; pel_sw = PW'(10 * i); pel_tb = 8'd5;
      tick();
    end
    idle_in();
    tick();
    chk("chain_ad", 64'(ad), 64'({8'd5, 8'd15, 8'd25, 8'd35}));
    chk("chain_nxt", {nxt_sw, nxt_tb}, {8'd10, 8'd5});

    // Four-beat block
    beat(1, 0);
    chk("blk_busy", {sad_valid, busy}, 64'b01);
    beat(0, 0);
    beat(0, 0);
    beat(0, 1);
    chk("blk_valid", {sad_valid, busy}, 64'b11);
    chk("blk_sad", 64'(sad), 64'({12'd20, 12'd60, 12'd100, 12'd140}));
    tick();
    chk("blk_pulse", {sad_valid, busy}, 64'b00);
    chk("blk_hold", 64'(sad), 64'({12'd20, 12'd60, 12'd100, 12'd140}));

    // Same block with idle gaps; plain acc_en in IDLE must be ignored
    beat(0, 0);
    beat(1, 0);
    tick();
    beat(0, 0);
    tick();
    tick();
    beat(0, 0);
    beat(0, 1);
    chk("gap_valid", 64'(sad_valid), 64'd1);
    chk("gap_sad", 64'(sad), 64'({12'd20, 12'd60, 12'd100, 12'd140}));
    tick();

    // Fifth SW shift only: sw = 50,40,30,20
    en_sw = 1; pel_sw = 8'd50;
    tick();
    idle_in();
    chk("shift5_nxt", 64'(nxt_sw), 64'd20);
    chk("shift5_ad", 64'(ad), 64'({8'd15, 8'd25, 8'd35, 8'd45}));

    // Single beat, then back-to-back start in the DONE cycle
    beat(1, 1);
    chk("single_valid", 64'(sad_valid), 64'd1);
    chk("single_sad", 64'(sad), 64'({12'd15, 12'd25, 12'd35, 12'd45}));
    beat(1, 0);
    chk("b2b_mid", {sad_valid, busy}, 64'b01);
    beat(0, 1);
    chk("b2b_valid", 64'(sad_valid), 64'd1);
    chk("b2b_sad", 64'(sad), 64'({12'd30, 12'd50, 12'd70, 12'd90}));
    beat(1, 1);
    chk("b2b_single_valid", 64'(sad_valid), 64'd1);
    chk("b2b_single_sad", 64'(sad), 64'({12'd15, 12'd25, 12'd35, 12'd45}));
    tick();

    // Restart after two beats: only the three beats from restart count
    beat(1, 0);
    beat(0, 0);
    beat(1, 0);
    beat(0, 0);
    beat(0, 1);
    chk("restart_sad", 64'(sad), 64'({12'd45, 12'd75, 12'd105, 12'd135}));
    tick();

    // Reset in the middle of a block
    beat(1, 0);
    beat(0, 0);
    rst = 1;
    tick();
    rst = 0;
    chk("abort_flags", {sad_valid, busy}, 64'b00);
    chk("abort_sad", 64'(sad), 64'd0);
    tick();
    chk("abort_novalid", 64'(sad_valid), 64'd0);

    // Overflow: ad = 255 in every PE for five beats (1275)
    for (int i = 0; i < 4; i++) begin
      en_sw = 1; pel_sw = 8'd255;
      tick();
    end
    idle_in();
    chk("ovf_ad", 64'(ad_o), 64'hFFFF_FFFF);
    beat(1, 0);
    for (int i = 0; i < 3; i++) beat(0, 0);
    beat(0, 1);
    chk("ovf_valid", {sad_valid_o, sad_valid}, 64'b11);
`ifdef PE_LINE_SAD_SAT_EN
    chk("ovf_sad10", 64'(sad_o), 64'({10'd1023, 10'd1023, 10'd1023, 10'd1023}));
`else
    chk("ovf_sad10", 64'(sad_o), 64'({10'd251, 10'd251, 10'd251, 10'd251}));
`endif
    chk("ovf_sad12", 64'(sad), 64'({12'd1275, 12'd1275, 12'd1275, 12'd1275}));
    tick();
    chk("ovf_idle", {busy_o, busy}, 64'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/pe_line_sad.md
# pe_line_sad

Parametrised systolic processing-element line for the motion-estimation array. It shifts search-window (SW) and template-block (TB) pixels through ARRAY_SIZE element registers and forms per-element absolute differences. Each element also accumulates those differences over a framed block, giving one SAD per candidate position. Lines chain through nxt_sw/nxt_tb to build the 2-D array. The SAD vectors feed the minimum-search stage.

## Interface
- ARRAY_SIZE, 16, number of PEs in the line (≥1)
- PIX_W, 8, pixel width in bits
- ACC_W, 16, SAD accumulator/result width per PE (≥PIX_W)
- clk  in  1  clock, all logic rising-edge
- rst  in  1  reset, synchronous, active-high
- en_sw  in  1  shift SW chain one position
- en_tb  in  1  shift TB chain one position
- pel_sw  in  PIX_W  SW pixel into PE 0
- pel_tb  in  PIX_W  TB pixel into PE 0
- nxt_sw  out  PIX_W  SW register of PE ARRAY_SIZE-1 (cascade)
- nxt_tb  out  PIX_W  TB register of PE ARRAY_SIZE-1 (cascade)
- acc_en  in  1  accumulate current AD this cycle
- acc_start  in  1  first beat of block; qualified by acc_en
- acc_last  in  1  last beat of block; qualified by acc_en
- ad  out  ARRAY_SIZE*PIX_W  per-PE |sw-tb|, PE i at bits [PIX_W*(i+1)-1:PIX_W*i]
- sad  out  ARRAY_SIZE*ACC_W  registered block SADs, PE i at bits [ACC_W*(i+1)-1:ACC_W*i]
- sad_valid  out  1  one-cycle strobe: sad updated
- busy  out  1  accumulation in progress

## Operation
- SW chain: on en_sw, sw[0]<=pel_sw, sw[i]<=sw[i-1]. TB chain is identical on en_tb. The two enables are independent.
- ad[i] = |sw[i]-tb[i]|, combinational from PE registers, unsigned PIX_W result.
- Accumulator acc[i], ACC_W bits. AD is zero-extended before adding.
- FSM states:
  - IDLE: acc_en&acc_start -> acc<=ad. Go to ACC, or to DONE if acc_last is also set. acc_en without start is ignored; acc holds.
  - ACC: acc_en&acc_start -> acc<=ad (restart; partial sum discarded). Otherwise acc_en -> acc<=acc+ad. acc_en&acc_last -> DONE. acc_en=0 -> hold.
  - DONE (1 cycle): sad<=acc, sad_valid=1. acc_en&acc_start here -> acc<=ad, go to ACC (or DONE again if acc_last is also set). Otherwise go to IDLE.
- sad holds its value until the next DONE. acc is cleared only by start or reset.
- busy=1 in ACC and DONE.
- acc_last is applied to the value computed on that same beat, including a restart beat.

## Timing
- Reset (rst=1 at an edge): all sw/tb/acc/sad registers 0, state IDLE. sad_valid=0, busy=0, ad=0, nxt_sw=nxt_tb=0.
- Reset mid-block aborts the block. No sad_valid is issued for it.
- Chain latency: a pixel reaches nxt_sw after ARRAY_SIZE enabled shifts. Idle cycles do not count.
- ad reflects registers after the edge that shifted them: zero cycles after the shift.
- Last beat at edge N -> sad_valid high during cycle N+1, with sad valid at the same time.
- Back-to-back blocks: a start in the DONE cycle gives zero gap. Throughput is one beat per cycle.

## Configuration
- PE_LINE_SAD_SAT_EN defined: each acc add saturates at 2^ACC_W-1 and stays there until the next start.
- Not defined: modulo 2^ACC_W wrap-around.
- Ports and timing are identical either way.

## Structure
- Package pe_line_pkg:
  - FSM state typedef (IDLE/ACC/DONE)
  - absolute-difference function
  - saturating/wrapping add function, selected by the macro
- Sub-module pe_sad_cell: one PE with sw/tb registers, ad, and acc. Generated ARRAY_SIZE times.
- Single shared FSM in pe_line_sad drives acc load/add enables to all cells.

## Test plan
- Reset: ARRAY_SIZE=4, PIX_W=8, ACC_W=12. Drive rst high for 2 cycles with random inputs -> all outputs 0, busy=0.
- Chain: shift sw 10,20,30,40 and tb 5,5,5,5 -> ad = {PE3..PE0} = {5,15,25,35}. Fifth en_sw with pel_sw=50 -> nxt_sw=20.
- Block: chains frozen. Beat 1 start, beats 2-3 plain, beat 4 last -> sad = {20,60,100,140}. sad_valid is a single pulse the cycle after beat 4. Inserting acc_en=0 gaps gives the same result.
- Single-beat and back-to-back: start&last in one beat -> sad=ad. A start in the DONE cycle -> second sad_valid exactly 1 cycle after the beat that carried last, with no dropped beat.
- Restart/abort: start in ACC after 2 beats -> sad counts only beats from the restart. rst during ACC -> no sad_valid, sad=0.
- Overflow: ACC_W=10, ad=255 for 5 beats -> sad=251 without PE_LINE_SAD_SAT_EN, 1023 with it.
